// File: rtl/alu_pkg.sv
// alu_pkg: shared byte-bus width and serializer state encoding.
package alu_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2} state_t;
endpackage

// File: rtl/prod_serializer_if.sv
// prod_serializer_if: product capture and byte-beat return handshake bundle.
interface prod_serializer_if #(parameter int DATA_W = alu_pkg::DATA_W);
  logic in_valid;
  logic in_ready;
  logic [2*DATA_W-1:0] in_p;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_last;
  logic out_hi;
  logic zero_flag;
  logic ovf_flag;
  modport master (
    output in_valid, in_p, out_ready,
    input in_ready, out_valid, out_data, out_last, out_hi, zero_flag, ovf_flag
  );
  modport slave (
    input in_valid, in_p, out_ready,
    output in_ready, out_valid, out_data, out_last, out_hi, zero_flag, ovf_flag
  );
endinterface

// File: rtl/prod_serializer.sv
// prod_serializer: returns a 16-bit product as low/high byte beats with zero/overflow flags.
// PROD_SER_SKIP_HI_EN drops the high beat when the product's upper half is zero.
module prod_serializer #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input logic clk,
  input logic rst,
  prod_serializer_if.slave bus
);
  import alu_pkg::*;
`ifdef PROD_SER_SKIP_HI_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  state_t state, nxt_state;
  logic [2*DATA_W-1:0] hold_p, nxt_p;
  logic big, last, fire, acc, nxt_big;
  always_comb begin
    big = |hold_p[2*DATA_W-1:DATA_W];
    last = state == HI || (SKIP && state == LO && !big);
    fire = state != IDLE && bus.out_ready;
    bus.in_ready = state == IDLE || (fire && last);
    acc = bus.in_valid && bus.in_ready;
    nxt_p = acc ? bus.in_p : hold_p;
    nxt_state = acc ? LO : fire ? (last ? IDLE : HI) : state;
    nxt_big = |nxt_p[2*DATA_W-1:DATA_W];
  end
  // outputs are registered from the next state so they are stable under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold_p <= '0;
      bus.out_valid <= 1'b0;
      bus.out_hi <= 1'b0;
      bus.out_last <= 1'b0;
      bus.out_data <= '0;
      bus.zero_flag <= 1'b0;
      bus.ovf_flag <= 1'b0;
    end else begin
      state <= nxt_state;
      hold_p <= nxt_p;
      bus.out_valid <= nxt_state != IDLE;
      bus.out_hi <= nxt_state == HI;
      bus.out_last <= nxt_state == HI || (SKIP && nxt_state == LO && !nxt_big);
      bus.out_data <= nxt_state == HI ? nxt_p[2*DATA_W-1:DATA_W] : nxt_p[DATA_W-1:0];
      bus.zero_flag <= nxt_state != IDLE && nxt_p == '0;
      bus.ovf_flag <= nxt_state != IDLE && nxt_big;
    end
  end
endmodule

// File: tb/tb_prod_serializer.sv
// tb_prod_serializer: directed and random checks of prod_serializer against a beat-queue model.
module tb_prod_serializer;
  localparam int W = alu_pkg::DATA_W;
`ifdef PROD_SER_SKIP_HI_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  prod_serializer_if #(.DATA_W(W)) bus();
  prod_serializer #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [W-1:0] d;
    logic last;
    logic hi;
    logic z;
    logic o;
  } beat_t;
  beat_t q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [2*W-1:0] p);
    logic z, o;
    z = p == '0;
    o = p[2*W-1:W] != '0;
    q.push_back('{p[W-1:0], SKIP && !o, 1'b0, z, o});
    if (!(SKIP && !o)) q.push_back('{p[2*W-1:W], 1'b1, 1'b1, z, o});
  endtask
  // A product can enter once at most one pending beat remains and it is leaving now.
  task automatic step(input logic iv, input logic [2*W-1:0] p, input logic ordy, input logic r);
    logic rdy;
    @(negedge clk);
    bus.in_valid = iv;
    bus.in_p = p;
    bus.out_ready = ordy;
    rst = r;
    #1;
    rdy = q.size() == 0 || (q.size() == 1 && ordy);
    if (!r) begin
      chk("in_ready", bus.in_ready, rdy);
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_last", bus.out_last, q[0].last);
        chk("out_hi", bus.out_hi, q[0].hi);
        chk("zero_flag", bus.zero_flag, q[0].z);
        chk("ovf_flag", bus.ovf_flag, q[0].o);
      end else begin
        chk("idle_zero", bus.zero_flag, 1'b0);
        chk("idle_ovf", bus.ovf_flag, 1'b0);
      end
    end
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (ordy && q.size() != 0) void'(q.pop_front());
      if (iv && rdy) push(p);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_p = '0;
    bus.out_ready = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(1, 16'h12C4, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 16'h00FF, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'hDEAD, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 16'h0001, 1, 0);
    step(1, 16'hFFFE, 1, 0);
    step(1, 16'hFFFE, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 16'h0000, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 16'h1234, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 16'h0A0B, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 16'h0037, 1, 0);
    step(1, 16'h0100, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      logic [2*W-1:0] p;
      case ($urandom_range(3))
        0: p = '0;
        1: p = {{W{1'b0}}, W'($urandom)};
        default: p = (2*W)'($urandom);
      endcase
      step(1'($urandom), p, $urandom_range(3) != 0, $urandom_range(60) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
